// File: rtl/uart_tx_fsm_pkg.sv
// Shared definitions for the UART TX path.
//   tx_state_t : transmit sequencer states
//   MUX_*      : line-select codes consumed by the TX output multiplexer
//   mux_code() : maps a sequencer state to its line-select code
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    // IDLE and STOP both drive the line high, so they share MUX_STOP.
    function automatic logic [1:0] mux_code(input tx_state_t st);
        logic [1:0] code;
        case (st)
            ST_START:  code = MUX_START;
            ST_DATA:   code = MUX_DATA;
            ST_PARITY: code = MUX_PAR;
            default:   code = MUX_STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Request/line-control bundle between a byte producer and the TX sequencer.
//   master : producer side  - drives P_DATA, DATA_VALID, PAR_EN, PAR_TYP;
//                             observes mux_sel, ser_data, par_bit, busy
//   slave  : sequencer side - the reverse
interface uart_tx_fsm_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  mux_sel, ser_data, par_bit, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output mux_sel, ser_data, par_bit, busy
    );

endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity generator for the TX payload.
//   data    : payload bits
//   par_typ : 0 = even parity, 1 = odd parity
//   par_bit : parity bit to transmit
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity is the plain XOR reduction; odd parity is its complement.
    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: latches a payload on DATA_VALID and walks the
// frame start, data (LSB first), optional parity, stop at one bit per CLK.
//   CLK : bit-rate clock
//   RST : asynchronous active-high reset (line reads stop/idle)
//   bus : slave side of uart_tx_fsm_if
//         in  P_DATA, DATA_VALID, PAR_EN, PAR_TYP
//         out mux_sel, ser_data, par_bit, busy (all registered)
module uart_tx_fsm
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_fsm_if.slave bus
);

    localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  ser_q, ser_d;
    logic [1:0]            mux_q;
    logic                  busy_q;
    logic                  par_calc;
    logic                  accept;

    // Parity is taken from the live inputs so it is registered on the
    // acceptance edge together with the payload.
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (bus.P_DATA),
        .par_typ (bus.PAR_TYP),
        .par_bit (par_calc)
    );

    assign accept = bus.DATA_VALID && ((state_q == ST_IDLE) || (state_q == ST_STOP));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        ser_d     = ser_q;

        case (state_q)
            ST_START:  state_d = ST_DATA;
            ST_DATA: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: state_d = ST_PARITY == state_q ? ST_STOP : state_q;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Acceptance from IDLE or STOP overrides the transition above,
        // which is what makes back-to-back frames gapless.
        if (accept) begin
            state_d   = ST_START;
            cnt_d     = '0;
            data_d    = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_bit_d = par_calc;
        end

        // ser_data is registered, so it is looked up with the next counter
        // value to line up with mux_sel = DATA.
        if (state_d == ST_DATA) begin
            ser_d = data_q[cnt_d];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            ser_q     <= 1'b0;
            mux_q     <= MUX_STOP;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            ser_q     <= ser_d;
            mux_q     <= mux_code(state_d);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign bus.mux_sel  = mux_q;
    assign bus.ser_data = ser_q;
    assign bus.par_bit  = par_bit_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed self-checking bench for uart_tx_fsm (8-bit and 5-bit instances).
module tb_uart_tx_fsm;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_fsm_if #(.DATA_WIDTH(8)) bus8 ();
    uart_tx_fsm_if #(.DATA_WIDTH(5)) bus5 ();

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus8)
    );

    uart_tx_fsm #(.DATA_WIDTH(5)) dut5 (
        .CLK (clk),
        .RST (rst),
        .bus (bus5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns 1 time unit after acceptance.
    task automatic send8(input logic [7:0] d, input logic pen, input logic ptyp);
        bus8.P_DATA     = d;
        bus8.PAR_EN     = pen;
        bus8.PAR_TYP    = ptyp;
        bus8.DATA_VALID = 1'b1;
        tick();
        bus8.DATA_VALID = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.P_DATA = '0; bus8.DATA_VALID = 1'b0; bus8.PAR_EN = 1'b0; bus8.PAR_TYP = 1'b0;
        bus5.P_DATA = '0; bus5.DATA_VALID = 1'b0; bus5.PAR_EN = 1'b0; bus5.PAR_TYP = 1'b0;
        #3;
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.ser_data !== 1'b0 || bus8.par_bit !== 1'b0 || bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset8: mux=%b ser=%b par=%b busy=%b, expected mux=01 ser=0 par=0 busy=0",
                     bus8.mux_sel, bus8.ser_data, bus8.par_bit, bus8.busy);
        end
        total++;
        if (bus5.mux_sel !== 2'b01 || bus5.ser_data !== 1'b0 || bus5.par_bit !== 1'b0 || bus5.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset5: mux=%b ser=%b par=%b busy=%b, expected mux=01 ser=0 par=0 busy=0",
                     bus5.mux_sel, bus5.ser_data, bus5.par_bit, bus5.busy);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: mux=%b busy=%b, expected mux=01 busy=0", bus8.mux_sel, bus8.busy);
        end
    endtask

    task automatic test_parity_even();
        logic [7:0] exp_ser;
        exp_ser = 8'b1010_0101;   // LSB first: 1,0,1,0,0,1,0,1
        send8(8'hA5, 1'b1, 1'b0);
        total++;
        if (bus8.mux_sel !== 2'b00 || bus8.busy !== 1'b1) begin
            bad++;
            $display("FAIL even_start: mux=%b busy=%b, expected mux=00 busy=1", bus8.mux_sel, bus8.busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bus8.mux_sel !== 2'b10 || bus8.ser_data !== exp_ser[i] || bus8.busy !== 1'b1) begin
                bad++;
                $display("FAIL even_data[%0d]: mux=%b ser=%b busy=%b, expected mux=10 ser=%b busy=1",
                         i, bus8.mux_sel, bus8.ser_data, bus8.busy, exp_ser[i]);
            end
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b11 || bus8.par_bit !== 1'b0 || bus8.busy !== 1'b1) begin
            bad++;
            $display("FAIL even_parity: mux=%b par=%b busy=%b, expected mux=11 par=0 busy=1",
                     bus8.mux_sel, bus8.par_bit, bus8.busy);
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b1) begin
            bad++;
            $display("FAIL even_stop: mux=%b busy=%b, expected mux=01 busy=1", bus8.mux_sel, bus8.busy);
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL even_idle: mux=%b busy=%b, expected mux=01 busy=0", bus8.mux_sel, bus8.busy);
        end
    endtask

    task automatic test_parity_odd();
        send8(8'hA5, 1'b1, 1'b1);
        total++;
        if (bus8.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL odd_par_start: par=%b, expected 1", bus8.par_bit);
        end
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (bus8.mux_sel !== 2'b11 || bus8.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL odd_parity: mux=%b par=%b, expected mux=11 par=1", bus8.mux_sel, bus8.par_bit);
        end
        tick();
        tick();
        total++;
        if (bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL odd_idle: busy=%b, expected 0", bus8.busy);
        end
    endtask

    task automatic test_no_parity();
        logic [7:0] exp_ser;
        exp_ser = 8'b0011_1100;   // LSB first: 0,0,1,1,1,1,0,0
        send8(8'h3C, 1'b0, 1'b1);
        total++;
        if (bus8.mux_sel !== 2'b00 || bus8.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL nopar_start: mux=%b par=%b, expected mux=00 par=1", bus8.mux_sel, bus8.par_bit);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bus8.mux_sel !== 2'b10 || bus8.ser_data !== exp_ser[i]) begin
                bad++;
                $display("FAIL nopar_data[%0d]: mux=%b ser=%b, expected mux=10 ser=%b",
                         i, bus8.mux_sel, bus8.ser_data, exp_ser[i]);
            end
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b1) begin
            bad++;
            $display("FAIL nopar_stop: mux=%b busy=%b, expected mux=01 busy=1", bus8.mux_sel, bus8.busy);
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL nopar_idle: mux=%b busy=%b, expected mux=01 busy=0", bus8.mux_sel, bus8.busy);
        end
    endtask

    task automatic test_ignore_mid();
        logic [7:0] exp_ser;
        exp_ser = 8'b1001_0111;   // 0x97, five ones -> even parity 1
        send8(8'h97, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bus8.mux_sel !== 2'b10 || bus8.ser_data !== exp_ser[i]) begin
                bad++;
                $display("FAIL ignore_data[%0d]: mux=%b ser=%b, expected mux=10 ser=%b",
                         i, bus8.mux_sel, bus8.ser_data, exp_ser[i]);
            end
            if (i == 3) begin
                bus8.P_DATA     = 8'h00;
                bus8.PAR_EN     = 1'b0;
                bus8.PAR_TYP    = 1'b1;
                bus8.DATA_VALID = 1'b1;
            end else if (i == 4) begin
                bus8.DATA_VALID = 1'b0;
            end
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b11 || bus8.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL ignore_parity: mux=%b par=%b, expected mux=11 par=1", bus8.mux_sel, bus8.par_bit);
        end
        tick();
        tick();
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_idle: mux=%b busy=%b, expected mux=01 busy=0", bus8.mux_sel, bus8.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        exp_a = 8'b0101_0101;
        exp_b = 8'b0000_1111;
        bus8.P_DATA     = 8'h55;
        bus8.PAR_EN     = 1'b0;
        bus8.PAR_TYP    = 1'b0;
        bus8.DATA_VALID = 1'b1;
        tick();
        total++;
        if (bus8.mux_sel !== 2'b00 || bus8.par_bit !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start1: mux=%b par=%b, expected mux=00 par=0", bus8.mux_sel, bus8.par_bit);
        end
        bus8.P_DATA  = 8'h0F;
        bus8.PAR_TYP = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bus8.mux_sel !== 2'b10 || bus8.ser_data !== exp_a[i]) begin
                bad++;
                $display("FAIL b2b_data1[%0d]: mux=%b ser=%b, expected mux=10 ser=%b",
                         i, bus8.mux_sel, bus8.ser_data, exp_a[i]);
            end
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_stop1: mux=%b busy=%b, expected mux=01 busy=1", bus8.mux_sel, bus8.busy);
        end
        tick();
        total++;
        if (bus8.mux_sel !== 2'b00 || bus8.busy !== 1'b1 || bus8.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL b2b_start2: mux=%b busy=%b par=%b, expected mux=00 busy=1 par=1",
                     bus8.mux_sel, bus8.busy, bus8.par_bit);
        end
        bus8.DATA_VALID = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bus8.mux_sel !== 2'b10 || bus8.ser_data !== exp_b[i]) begin
                bad++;
                $display("FAIL b2b_data2[%0d]: mux=%b ser=%b, expected mux=10 ser=%b",
                         i, bus8.mux_sel, bus8.ser_data, exp_b[i]);
            end
        end
        tick();
        tick();
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: mux=%b busy=%b, expected mux=01 busy=0", bus8.mux_sel, bus8.busy);
        end
    endtask

    task automatic test_reset_mid();
        // 0x5A: bit3 = 1, four ones -> odd parity 1
        send8(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (bus8.mux_sel !== 2'b10 || bus8.ser_data !== 1'b1 || bus8.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL rmid_before: mux=%b ser=%b par=%b, expected mux=10 ser=1 par=1",
                     bus8.mux_sel, bus8.ser_data, bus8.par_bit);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0 || bus8.ser_data !== 1'b0 || bus8.par_bit !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async: mux=%b busy=%b ser=%b par=%b, expected mux=01 busy=0 ser=0 par=0",
                     bus8.mux_sel, bus8.busy, bus8.ser_data, bus8.par_bit);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus8.mux_sel !== 2'b01 || bus8.busy !== 1'b0) begin
                bad++;
                $display("FAIL rmid_idle[%0d]: mux=%b busy=%b, expected mux=01 busy=0",
                         i, bus8.mux_sel, bus8.busy);
            end
        end
    endtask

    task automatic test_width5();
        logic [4:0] exp_ser;
        exp_ser = 5'b10011;   // LSB first: 1,1,0,0,1; three ones -> even parity 1
        bus5.P_DATA     = 5'b10011;
        bus5.PAR_EN     = 1'b1;
        bus5.PAR_TYP    = 1'b0;
        bus5.DATA_VALID = 1'b1;
        tick();
        bus5.DATA_VALID = 1'b0;
        total++;
        if (bus5.mux_sel !== 2'b00 || bus5.busy !== 1'b1 || bus5.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL w5_start: mux=%b busy=%b par=%b, expected mux=00 busy=1 par=1",
                     bus5.mux_sel, bus5.busy, bus5.par_bit);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus5.mux_sel !== 2'b10 || bus5.ser_data !== exp_ser[i]) begin
                bad++;
                $display("FAIL w5_data[%0d]: mux=%b ser=%b, expected mux=10 ser=%b",
                         i, bus5.mux_sel, bus5.ser_data, exp_ser[i]);
            end
        end
        tick();
        total++;
        if (bus5.mux_sel !== 2'b11 || bus5.par_bit !== 1'b1) begin
            bad++;
            $display("FAIL w5_parity: mux=%b par=%b, expected mux=11 par=1", bus5.mux_sel, bus5.par_bit);
        end
        tick();
        total++;
        if (bus5.mux_sel !== 2'b01 || bus5.busy !== 1'b1) begin
            bad++;
            $display("FAIL w5_stop: mux=%b busy=%b, expected mux=01 busy=1", bus5.mux_sel, bus5.busy);
        end
        tick();
        total++;
        if (bus5.mux_sel !== 2'b01 || bus5.busy !== 1'b0) begin
            bad++;
            $display("FAIL w5_idle: mux=%b busy=%b, expected mux=01 busy=0", bus5.mux_sel, bus5.busy);
        end
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_parity_odd();
        test_no_parity();
        test_ignore_mid();
        test_back_to_back();
        test_reset_mid();
        test_width5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
